// File: rtl/draw_screen_mode.sv
`default_nettype none
// ============================================================================
// Module   : draw_screen_mode
// Purpose  : Per-pixel background renderer and screen-mode controller for
//            the 1024x768 VGA pipeline. Tracks MENU/GAME/PAUSE/OVER, collects
//            mode requests from buttons, game logic and mouse clicks, and
//            commits them only at the vblank rising edge so a frame is never
//            drawn in two modes. Timing passes through with one cycle delay.
// Ports    : pclk, rst (sync, active-high)
//            hcount_in/vcount_in/hsync_in/vsync_in/hblnk_in/vblnk_in : timing
//            xpos/ypos/mouse_left : mouse state
//            game_on/menu_on/game_over/pause_req : mode requests
//            *_out : timing delayed by 1 cycle, rgb_out : pixel colour
//            mode : committed mode, play_selected : mode==GAME,
//            hover : cursor inside the PLAY button
// Revision : 1.0 - initial release
// ============================================================================
module draw_screen_mode #(
  parameter int          H_ACTIVE      = 1024,
  parameter int          V_ACTIVE      = 768,
  parameter int          TOP_V_LINE    = 317,
  parameter int          BOTTOM_V_LINE = 617,
  parameter int          LEFT_H_LINE   = 361,
  parameter int          RIGHT_H_LINE  = 661,
  parameter int          BORDER        = 10,
  parameter int          BTN_X         = 422,
  parameter int          BTN_Y         = 390,
  parameter int          BTN_W         = 123,
  parameter int          BTN_H         = 90,
  parameter logic [11:0] BG_MENU       = 12'h000,
  parameter logic [11:0] BG_GAME       = 12'h000,
  parameter logic [11:0] BG_OVER       = 12'h192,
  parameter logic [11:0] ARENA_RGB     = 12'hfff,
  parameter logic [11:0] PAUSE_RGB     = 12'h888,
  parameter logic [11:0] BTN_RGB       = 12'hfff,
  parameter logic [11:0] BTN_HOVER_RGB = 12'h0f0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        game_on,
  input  logic        menu_on,
  input  logic        game_over,
  input  logic        pause_req,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [1:0]  mode,
  output logic        play_selected,
  output logic        hover
);

  localparam logic [1:0] c_MODE_MENU  = 2'b00;
  localparam logic [1:0] c_MODE_GAME  = 2'b01;
  localparam logic [1:0] c_MODE_PAUSE = 2'b10;
  localparam logic [1:0] c_MODE_OVER  = 2'b11;

  // Geometry as 12-bit constants so every compare is width-matched.
  localparam logic [11:0] c_BTN_X0   = 12'(BTN_X);
  localparam logic [11:0] c_BTN_X1   = 12'(BTN_X + BTN_W);
  localparam logic [11:0] c_BTN_Y0   = 12'(BTN_Y);
  localparam logic [11:0] c_BTN_Y1   = 12'(BTN_Y + BTN_H);
  localparam logic [11:0] c_IN_L     = 12'(LEFT_H_LINE);
  localparam logic [11:0] c_IN_R     = 12'(RIGHT_H_LINE);
  localparam logic [11:0] c_IN_T     = 12'(TOP_V_LINE);
  localparam logic [11:0] c_IN_B     = 12'(BOTTOM_V_LINE);
  localparam logic [11:0] c_OUT_L    = 12'(LEFT_H_LINE - BORDER);
  localparam logic [11:0] c_OUT_R    = 12'(RIGHT_H_LINE + BORDER);
  localparam logic [11:0] c_OUT_T    = 12'(TOP_V_LINE - BORDER);
  localparam logic [11:0] c_OUT_B    = 12'(BOTTOM_V_LINE + BORDER);
  localparam logic [11:0] c_H_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] c_V_LAST   = 12'(V_ACTIVE - 1);

  logic [1:0]  r_mode;
  logic        r_pending_valid;
  logic [1:0]  r_pending_mode;
  logic        r_mouse_left_d;
  logic        r_pause_d;
  logic        r_vblnk_d;

  logic        w_click;
  logic        w_ptog;
  logic        w_in_btn;
  logic        w_frame_edge;
  logic [1:0]  w_req_mode;
  logic        w_req_valid;
  logic [1:0]  w_mode_nxt;
  logic        w_pending_valid_nxt;
  logic [1:0]  w_pending_mode_nxt;
  logic        w_px_in_btn;
  logic        w_px_arena;
  logic [11:0] w_rgb_nxt;

  assign w_click      = mouse_left & ~r_mouse_left_d;
  assign w_ptog       = pause_req & ~r_pause_d;
  assign w_frame_edge = vblnk_in & ~r_vblnk_d;
  assign w_in_btn     = (xpos >= c_BTN_X0) && (xpos < c_BTN_X1) &&
                        (ypos >= c_BTN_Y0) && (ypos < c_BTN_Y1);

  assign w_px_in_btn  = (hcount_in >= c_BTN_X0) && (hcount_in < c_BTN_X1) &&
                        (vcount_in >= c_BTN_Y0) && (vcount_in < c_BTN_Y1);

  // Frame ring: inside the outer box but outside the inclusive inner box.
  assign w_px_arena   = (hcount_in >= c_OUT_L) && (hcount_in <= c_OUT_R) &&
                        (vcount_in >= c_OUT_T) && (vcount_in <= c_OUT_B) &&
                        !((hcount_in >= c_IN_L) && (hcount_in <= c_IN_R) &&
                          (vcount_in >= c_IN_T) && (vcount_in <= c_IN_B));

  // State register: committed mode, pending request and edge detectors.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_mode          <= c_MODE_MENU;
      r_pending_valid <= 1'b0;
      r_pending_mode  <= c_MODE_MENU;
      r_mouse_left_d  <= 1'b0;
      r_pause_d       <= 1'b0;
      r_vblnk_d       <= 1'b0;
    end else begin
      r_mode          <= w_mode_nxt;
      r_pending_valid <= w_pending_valid_nxt;
      r_pending_mode  <= w_pending_mode_nxt;
      r_mouse_left_d  <= mouse_left;
      r_pause_d       <= pause_req;
      r_vblnk_d       <= vblnk_in;
    end
  end

  // Next-state: request target (first match wins), then commit/pend.
  always_comb begin
    w_req_mode = r_mode;
    case (r_mode)
      c_MODE_MENU: begin
        if (game_on || (w_click && w_in_btn)) w_req_mode = c_MODE_GAME;
        else if (game_over)                   w_req_mode = c_MODE_OVER;
      end
      c_MODE_GAME: begin
        if (menu_on)        w_req_mode = c_MODE_MENU;
        else if (game_over) w_req_mode = c_MODE_OVER;
        else if (w_ptog)    w_req_mode = c_MODE_PAUSE;
      end
      c_MODE_PAUSE: begin
        if (menu_on)                              w_req_mode = c_MODE_MENU;
        else if (w_ptog || (w_click && w_in_btn)) w_req_mode = c_MODE_GAME;
      end
      default: begin
        if (game_on || (w_click && w_in_btn))       w_req_mode = c_MODE_GAME;
        else if (menu_on || (w_click && !w_in_btn)) w_req_mode = c_MODE_MENU;
      end
    endcase
    // A target equal to the current mode is not a request.
    w_req_valid = (w_req_mode != r_mode);

    w_mode_nxt          = r_mode;
    w_pending_valid_nxt = r_pending_valid;
    w_pending_mode_nxt  = r_pending_mode;
    if (w_frame_edge && w_req_valid) begin
      w_mode_nxt          = w_req_mode;
      w_pending_valid_nxt = 1'b0;
      w_pending_mode_nxt  = c_MODE_MENU;
    end else if (w_frame_edge && r_pending_valid) begin
      w_mode_nxt          = r_pending_mode;
      w_pending_valid_nxt = 1'b0;
      w_pending_mode_nxt  = c_MODE_MENU;
    end else if (w_req_valid) begin
      w_pending_valid_nxt = 1'b1;
      w_pending_mode_nxt  = w_req_mode;
    end
  end

  // Output: pixel colour from the mode committed at the start of the cycle.
  always_comb begin
    w_rgb_nxt = BG_MENU;
    if (hblnk_in || vblnk_in) begin
      w_rgb_nxt = 12'h000;
    end else if (vcount_in == 12'd0) begin
      w_rgb_nxt = 12'hff0;
    end else if (vcount_in == c_V_LAST) begin
      w_rgb_nxt = 12'hf00;
    end else if (hcount_in == 12'd0) begin
      w_rgb_nxt = 12'h0f0;
    end else if (hcount_in == c_H_LAST) begin
      w_rgb_nxt = 12'h00f;
    end else if ((r_mode == c_MODE_GAME || r_mode == c_MODE_PAUSE) && w_px_arena) begin
      w_rgb_nxt = (r_mode == c_MODE_GAME) ? ARENA_RGB : PAUSE_RGB;
    end else if (r_mode != c_MODE_GAME && w_px_in_btn) begin
      w_rgb_nxt = w_in_btn ? BTN_HOVER_RGB : BTN_RGB;
    end else begin
      case (r_mode)
        c_MODE_MENU: w_rgb_nxt = BG_MENU;
        c_MODE_OVER: w_rgb_nxt = BG_OVER;
        default:     w_rgb_nxt = BG_GAME;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= 12'd0;
      vcount_out <= 12'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
      hover      <= 1'b0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= w_rgb_nxt;
      hover      <= w_in_btn;
    end
  end

  assign mode          = r_mode;
  assign play_selected = (r_mode == c_MODE_GAME);

endmodule
`default_nettype wire

// File: tb/tb_draw_screen_mode.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_screen_mode
// Purpose  : Directed self-checking bench for draw_screen_mode. Frames are
//            shortened to a vblank pulse plus a handful of chosen pixels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_screen_mode;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        mouse_left, game_on, menu_on, game_over, pause_req;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [1:0]  mode;
  logic        play_selected, hover;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [11:0] rgb;
    logic [11:0] h;
    logic [11:0] v;
    logic [3:0]  flags;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  always #5 pclk = ~pclk;

  draw_screen_mode dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
    .game_on(game_on), .menu_on(menu_on), .game_over(game_over),
    .pause_req(pause_req),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .mode(mode),
    .play_selected(play_selected), .hover(hover)
  );

  task automatic check(input logic [11:0] act, input logic [11:0] exp, input string tag);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, act, exp);
    end
  endtask

  // Push the expectation for the pixel currently driven, clock it, then pop
  // and compare against what the DUT presents one cycle later.
  task automatic cycle(input logic chk, input logic [11:0] exp_rgb, input string tag);
    exp_t  e;
    string t;
    e.chk = chk;
    e.rgb = exp_rgb;
    if (rst) begin
      e.h = 12'd0; e.v = 12'd0; e.flags = 4'd0;
    end else begin
      e.h = hcount_in; e.v = vcount_in;
      e.flags = {hsync_in, vsync_in, hblnk_in, vblnk_in};
    end
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge pclk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    if (e.chk) begin
      check(rgb_out, e.rgb, {t, "_rgb"});
      checks++;
      assert ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}
              === {e.h, e.v, e.flags}) else begin
        errors++;
        $error("FAIL %s_timing observed %h/%h/%b expected %h/%h/%b", t,
               hcount_out, vcount_out,
               {hsync_out, vsync_out, hblnk_out, vblnk_out}, e.h, e.v, e.flags);
      end
    end
  endtask

  task automatic px(input logic [11:0] h, input logic [11:0] v);
    hcount_in = h; vcount_in = v;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
  endtask

  task automatic blank();
    hcount_in = 12'd1100; vcount_in = 12'd770;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
  endtask

  // Short frame: vblank rises (commit cycle), stays high a cycle, then a
  // mid-frame pixel.
  task automatic frame();
    blank();
    cycle(1'b1, 12'h000, "vblank");
    cycle(1'b0, 12'h000, "vblank_hold");
    px(12'd200, 12'd300);
    cycle(1'b0, 12'h000, "midframe");
  endtask

  initial begin
    rst = 1'b1;
    xpos = 12'd0; ypos = 12'd0;
    mouse_left = 1'b0; game_on = 1'b0; menu_on = 1'b0;
    game_over = 1'b0; pause_req = 1'b0;
    px(12'd0, 12'd5);

    // Reset state
    cycle(1'b1, 12'h000, "reset");
    cycle(1'b1, 12'h000, "reset2");
    check(12'(mode), 12'h0, "reset_mode");
    check(12'(play_selected), 12'h0, "reset_play");
    check(12'(hover), 12'h0, "reset_hover");
    rst = 1'b0;

    // Idle menu frames
    frame();
    frame();
    check(12'(mode), 12'h0, "idle_mode");
    check(12'(play_selected), 12'h0, "idle_play");
    px(12'd430, 12'd400);  cycle(1'b1, 12'hfff, "menu_btn");
    px(12'd0, 12'd5);      cycle(1'b1, 12'h0f0, "left_edge");
    px(12'd5, 12'd0);      cycle(1'b1, 12'hff0, "top_edge");
    px(12'd5, 12'd767);    cycle(1'b1, 12'hf00, "bottom_edge");
    px(12'd1023, 12'd5);   cycle(1'b1, 12'h00f, "right_edge");
    px(12'd100, 12'd100);  cycle(1'b1, 12'h000, "menu_bg");
    px(12'd430, 12'd400);  hblnk_in = 1'b1;
    cycle(1'b1, 12'h000, "hblank");

    // MENU: mid-frame click on the button, held until the frame edge
    xpos = 12'd450; ypos = 12'd420;
    px(12'd200, 12'd300);  cycle(1'b0, 12'h000, "hover_move");
    check(12'(hover), 12'h1, "hover_on");
    mouse_left = 1'b1;     cycle(1'b0, 12'h000, "click");
    cycle(1'b0, 12'h000, "click_held");
    mouse_left = 1'b0;
    px(12'd430, 12'd400);  cycle(1'b1, 12'h0f0, "menu_btn_hover");
    check(12'(mode), 12'h0, "mode_before_edge");
    blank();
    check(12'(mode), 12'h0, "mode_at_edge");
    cycle(1'b1, 12'h000, "commit_edge");
    check(12'(mode), 12'h1, "mode_after_edge");
    check(12'(play_selected), 12'h1, "game_play");
    px(12'd355, 12'd400);  cycle(1'b1, 12'hfff, "game_arena");
    px(12'd430, 12'd400);  cycle(1'b1, 12'h000, "game_no_btn");
    check(12'(hover), 12'h1, "game_hover");

    // GAME: pause_req held for three frames toggles once
    pause_req = 1'b1;
    cycle(1'b0, 12'h000, "pause_rise");
    frame();
    check(12'(mode), 12'h2, "pause_first");
    frame();
    frame();
    check(12'(mode), 12'h2, "pause_held");
    check(12'(play_selected), 12'h0, "pause_play");
    px(12'd355, 12'd400);  cycle(1'b1, 12'h888, "pause_arena");
    px(12'd430, 12'd400);  cycle(1'b1, 12'h0f0, "pause_btn_hover");
    pause_req = 1'b0;      cycle(1'b0, 12'h000, "pause_release");
    pause_req = 1'b1;      cycle(1'b0, 12'h000, "pause_pulse");
    pause_req = 1'b0;
    frame();
    check(12'(mode), 12'h1, "resume");

    // GAME: menu_on beats game_over
    game_over = 1'b1; menu_on = 1'b1;
    cycle(1'b0, 12'h000, "menu_vs_over");
    game_over = 1'b0; menu_on = 1'b0;
    frame();
    check(12'(mode), 12'h0, "menu_priority");

    // OVER: click outside the button returns to MENU
    game_over = 1'b1;      cycle(1'b0, 12'h000, "to_over");
    game_over = 1'b0;
    frame();
    check(12'(mode), 12'h3, "over_mode");
    px(12'd100, 12'd100);  cycle(1'b1, 12'h192, "over_bg");
    xpos = 12'd10; ypos = 12'd10;
    cycle(1'b0, 12'h000, "cursor_out");
    check(12'(hover), 12'h0, "hover_off");
    px(12'd430, 12'd400);  cycle(1'b1, 12'hfff, "over_btn");
    mouse_left = 1'b1;     cycle(1'b0, 12'h000, "over_click_out");
    mouse_left = 1'b0;
    frame();
    check(12'(mode), 12'h0, "over_to_menu");

    // OVER: click on the button goes to GAME
    game_over = 1'b1;      cycle(1'b0, 12'h000, "to_over2");
    game_over = 1'b0;
    frame();
    check(12'(mode), 12'h3, "over_mode2");
    xpos = 12'd450; ypos = 12'd420;
    cycle(1'b0, 12'h000, "cursor_in");
    mouse_left = 1'b1;     cycle(1'b0, 12'h000, "over_click_in");
    mouse_left = 1'b0;
    frame();
    check(12'(mode), 12'h1, "over_to_game");

    // Request raised on the frame-edge cycle itself commits immediately
    blank(); menu_on = 1'b1;
    cycle(1'b1, 12'h000, "edge_request");
    menu_on = 1'b0;
    check(12'(mode), 12'h0, "edge_commit");
    cycle(1'b0, 12'h000, "edge_hold");

    // Reset between a mid-frame request and the next vblank drops it
    px(12'd200, 12'd300);
    mouse_left = 1'b1;     cycle(1'b0, 12'h000, "pre_reset_click");
    mouse_left = 1'b0;     cycle(1'b0, 12'h000, "pre_reset_idle");
    rst = 1'b1; px(12'd0, 12'd5);
    cycle(1'b1, 12'h000, "reset_mid");
    rst = 1'b0;
    frame();
    check(12'(mode), 12'h0, "reset_discard");
    px(12'd0, 12'd5);      cycle(1'b1, 12'h0f0, "post_reset_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_screen_mode.md
# draw_screen_mode

Parametrised per-pixel background renderer and screen-mode controller for the 1024x768 VGA pipeline, placed directly after the timing generator and ahead of the sprite/mouse overlay stages. It tracks four modes (MENU, GAME, PAUSE, OVER), takes requests from board buttons, game logic and mouse clicks, and commits mode changes only at frame boundaries so the picture never tears. Timing signals pass through with one cycle of delay, aligned with `rgb_out`.

## Interface
Parameters:
- H_ACTIVE, 1024 — visible pixels per line
- V_ACTIVE, 768 — visible lines
- TOP_V_LINE / BOTTOM_V_LINE / LEFT_H_LINE / RIGHT_H_LINE, 317 / 617 / 361 / 661 — inner arena edges
- BORDER, 10 — arena frame thickness in pixels, drawn outside the inner edges
- BTN_X / BTN_Y / BTN_W / BTN_H, 422 / 390 / 123 / 90 — PLAY button box; origin is inclusive, end is exclusive
- BG_MENU / BG_GAME / BG_OVER, 12'h000 / 12'h000 / 12'h192 — fill colour per mode
- ARENA_RGB / PAUSE_RGB, 12'hfff / 12'h888 — arena frame colour in GAME / PAUSE
- BTN_RGB / BTN_HOVER_RGB, 12'hfff / 12'h0f0 — button colour, normal and under cursor

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- hcount_in, vcount_in  in  12  pixel position
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  timing inputs
- xpos, ypos  in  12  mouse position
- mouse_left  in  1  left mouse button level
- game_on, menu_on, game_over  in  1  level requests
- pause_req  in  1  pause toggle level; acts on its rising edge
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  12/1  timing delayed by 1 cycle
- rgb_out  out  12  pixel colour
- mode  out  2  committed mode: MENU=00, GAME=01, PAUSE=10, OVER=11
- play_selected  out  1  high when mode==GAME
- hover  out  1  cursor inside the button box

## Operation
- Internal signals:
  - click = mouse_left & ~mouse_left_d.
  - ptog = pause_req & ~pause_d.
  - in_btn = BTN_X<=xpos<BTN_X+BTN_W and BTN_Y<=ypos<BTN_Y+BTN_H.
  - frame_edge = vblnk_in & ~vblnk_d.
- Request target, evaluated against the committed mode; the first true condition wins:
  - MENU: game_on or (click & in_btn) -> GAME; game_over -> OVER.
  - GAME: menu_on -> MENU; game_over -> OVER; ptog -> PAUSE.
  - PAUSE: menu_on -> MENU; ptog or (click & in_btn) -> GAME.
  - OVER: game_on or (click & in_btn) -> GAME; menu_on or (click & ~in_btn) -> MENU.
- A request whose target equals the current mode is not a request.
- pending_valid / pending_mode:
  - A new request overwrites the pending target.
  - Both are cleared on commit.
- Commit happens on a frame_edge cycle:
  - mode <= the request raised in that same cycle if there is one, otherwise pending_mode if pending_valid.
  - With neither, mode is unchanged.
- Pixel priority (uses the committed mode as registered at the start of the cycle):
  1. Blanking -> 000.
  2. Screen edges: vcount==0 -> ff0; vcount==V_ACTIVE-1 -> f00; hcount==0 -> 0f0; hcount==H_ACTIVE-1 -> 00f.
  3. GAME/PAUSE: arena frame -> ARENA_RGB (GAME) or PAUSE_RGB (PAUSE).
  4. MENU/PAUSE/OVER: pixel inside the button box -> BTN_HOVER_RGB if hover_nxt, else BTN_RGB.
  5. Otherwise the mode fill; PAUSE uses BG_GAME.

## Timing
- Latency is 1 cycle for all outputs: rgb and timing outputs for pixel N appear together on the next rising edge.
- A mode change reaches `mode` one cycle after its frame_edge. The first pixel rendered in the new mode is the first pixel that enters one cycle after that commit edge, so all active pixels of the next frame use the new mode.
- Reset values:
  - All outputs are 0; mode = MENU.
  - pending_valid = 0, mouse_left_d = 0, pause_d = 0, vblnk_d = 0.
  - If vblnk_in is high in the first cycle after reset, that cycle counts as a frame_edge.
- A held mouse_left or pause_req produces exactly one event.
- A click that occurs mid-frame is held in pending and is not lost.
- Reset asserted mid-frame discards any pending request.
- hover is registered from in_btn and is valid in every mode.

## Test plan
- Reset, then run 2 frames with no input -> mode=00, play_selected=0, button pixel (430,400) = fff, pixel (0,5) = 0f0.
- In MENU, cursor at (450,420), click pulse at mid-frame line 300 -> mode stays 00 until the vblank rising edge, 01 one cycle later; hover=1; arena pixel (355,400) = fff in the next frame.
- In GAME, hold pause_req for 3 frames -> mode=10 after the first vblank only; arena pixel = 888. Release and re-pulse pause_req -> mode=01.
- In GAME, game_over and menu_on asserted in the same cycle -> mode=00 (menu_on has priority).
- In OVER, click at (10,10) -> mode=00 at the next frame; the same click at (450,420) -> mode=01.
- Request raised on the exact frame_edge cycle -> commits that cycle. Reset pulse between a mid-frame request and the next vblank -> mode=00, no commit.
